// File: rtl/telemetry_pkg.sv
// Shared constants and FSM state type for the serial telemetry receiver.
package telemetry_pkg;

  localparam int TELEM_PACKET_WIDTH    = 88;
  localparam int TELEM_CNT_WIDTH       = 16;
  localparam int TELEM_SAMPLES_PER_BIT = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } telem_state_t;

endpackage

// File: rtl/telemetry_bit_sampler.sv
// Line front end: 2-flop synchronizer, edge detect and mid-bit strobe generation.
// The phase counter restarts on any edge of the synchronized line while realign_en is high.
module telemetry_bit_sampler #(
  parameter int SAMPLES_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serial_in,
  input  logic realign_en,
  output logic s,
  output logic rise,
  output logic strobe
);

  localparam int PHW = $clog2(SAMPLES_PER_BIT);
  localparam logic [PHW-1:0] PH_MID  = PHW'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [PHW-1:0] PH_LAST = PHW'(SAMPLES_PER_BIT - 1);

  logic           sync1_r;
  logic           sync2_r;
  logic           s_d_r;
  logic [PHW-1:0] ph_r;
  logic           edge_s;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      s_d_r   <= 1'b0;
    end else begin
      sync1_r <= serial_in;
      sync2_r <= sync1_r;
      s_d_r   <= sync2_r;
    end
  end

  assign edge_s = sync2_r ^ s_d_r;

  // Bit phase counter; an edge zeroes it so the strobe lands mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_r <= {PHW{1'b0}};
    end else if (realign_en && edge_s) begin
      ph_r <= {PHW{1'b0}};
    end else if (ph_r == PH_LAST) begin
      ph_r <= {PHW{1'b0}};
    end else begin
      ph_r <= ph_r + PHW'(1);
    end
  end

  assign s      = sync2_r;
  assign rise   = sync2_r & ~s_d_r;
  assign strobe = (ph_r == PH_MID);

endmodule

// File: rtl/telemetry_deserialize.sv
// Telemetry link receiver: frame FSM, payload shift register and saturating frame counters.
// Define TELEM_DESER_PARITY_EN to expect an even-parity bit between payload and stop bit.
module telemetry_deserialize
  import telemetry_pkg::*;
#(
  parameter int PACKET_WIDTH    = TELEM_PACKET_WIDTH,
  parameter int SAMPLES_PER_BIT = TELEM_SAMPLES_PER_BIT,
  parameter int CNT_WIDTH       = TELEM_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    serial_in,
  input  logic                    clear_counts,
  output logic [PACKET_WIDTH-1:0] packet,
  output logic                    packet_valid,
  output logic                    frame_error,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    good_count,
  output logic [CNT_WIDTH-1:0]    error_count
);

  localparam int BCW = $clog2(PACKET_WIDTH);

`ifdef TELEM_DESER_PARITY_EN
  localparam telem_state_t AFTER_DATA = PARITY;
`else
  localparam telem_state_t AFTER_DATA = STOP;
`endif

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_WIDTH'(1);
    end
  endfunction

  function automatic logic even_parity(input logic [PACKET_WIDTH-1:0] d);
    even_parity = ^d;
  endfunction

  telem_state_t            state_r;
  telem_state_t            state_nxt_s;
  logic [BCW-1:0]          bit_cnt_r;
  logic [PACKET_WIDTH-1:0] shift_r;
  logic [PACKET_WIDTH-1:0] packet_r;
  logic                    packet_valid_r;
  logic                    frame_error_r;
  logic                    pend_r;
  logic                    par_err_r;
  logic [CNT_WIDTH-1:0]    good_cnt_r;
  logic [CNT_WIDTH-1:0]    err_cnt_r;

  logic s_s;
  logic rise_s;
  logic strobe_s;
  logic realign_s;
  logic load_cnt_s;
  logic shift_en_s;
  logic par_chk_s;
  logic good_frame_s;
  logic bad_frame_s;

  // START keeps free-running phase so a short glitch cannot stretch its own check.
  assign realign_s = (state_r != START);

  telemetry_bit_sampler #(
    .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
  ) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_in (serial_in),
    .realign_en(realign_s),
    .s         (s_s),
    .rise      (rise_s),
    .strobe    (strobe_s)
  );

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle datapath controls.
  always_comb begin
    state_nxt_s  = state_r;
    load_cnt_s   = 1'b0;
    shift_en_s   = 1'b0;
    par_chk_s    = 1'b0;
    good_frame_s = 1'b0;
    bad_frame_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s || pend_r) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (strobe_s && s_s) begin
          state_nxt_s = DATA;
          load_cnt_s  = 1'b1;
        end else if (strobe_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (strobe_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == {BCW{1'b0}}) begin
            state_nxt_s = AFTER_DATA;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
`ifdef TELEM_DESER_PARITY_EN
        if (strobe_s) begin
          par_chk_s   = 1'b1;
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
`else
        state_nxt_s = IDLE;
`endif
      end
      STOP: begin
        if (strobe_s) begin
          state_nxt_s = IDLE;
          if (s_s || par_err_r) begin
            bad_frame_s = 1'b1;
          end else begin
            good_frame_s = 1'b1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Payload shifting, parity check and registered frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r      <= {BCW{1'b0}};
      shift_r        <= {PACKET_WIDTH{1'b0}};
      packet_r       <= {PACKET_WIDTH{1'b0}};
      packet_valid_r <= 1'b0;
      frame_error_r  <= 1'b0;
      pend_r         <= 1'b0;
      par_err_r      <= 1'b0;
    end else begin
      // An edge coinciding with the stop strobe would otherwise be missed by IDLE.
      pend_r         <= (state_r == STOP) && strobe_s && rise_s;
      packet_valid_r <= good_frame_s;
      frame_error_r  <= bad_frame_s;
      if (load_cnt_s) begin
        bit_cnt_r <= BCW'(PACKET_WIDTH - 1);
      end else if (shift_en_s && (bit_cnt_r != {BCW{1'b0}})) begin
        bit_cnt_r <= bit_cnt_r - BCW'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (shift_en_s) begin
        shift_r <= {shift_r[PACKET_WIDTH-2:0], s_s};
      end else begin
        shift_r <= shift_r;
      end
      if (load_cnt_s) begin
        par_err_r <= 1'b0;
      end else if (par_chk_s) begin
        par_err_r <= (s_s != even_parity(shift_r));
      end else begin
        par_err_r <= par_err_r;
      end
      if (good_frame_s) begin
        packet_r <= shift_r;
      end else begin
        packet_r <= packet_r;
      end
    end
  end

  // Saturating frame counters; a clear outranks a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_r <= {CNT_WIDTH{1'b0}};
      err_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else if (clear_counts) begin
      good_cnt_r <= {CNT_WIDTH{1'b0}};
      err_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      good_cnt_r <= good_frame_s ? sat_inc(good_cnt_r) : good_cnt_r;
      err_cnt_r  <= bad_frame_s  ? sat_inc(err_cnt_r)  : err_cnt_r;
    end
  end

  assign packet       = packet_r;
  assign packet_valid = packet_valid_r;
  assign frame_error  = frame_error_r;
  assign busy         = (state_r != IDLE);
  assign good_count   = good_cnt_r;
  assign error_count  = err_cnt_r;

endmodule

// File: tb/tb_telemetry_deserialize.sv
// Directed bench for telemetry_deserialize: vector table of whole frames plus
// hand sequences for glitch, back-to-back jitter, saturation, reset abort and clear.
module tb_telemetry_deserialize;

  localparam int PW  = 88;
  localparam int SPB = 4;
`ifdef TELEM_DESER_PARITY_EN
  localparam int STOP_IDX = 90;
  localparam int NV       = 6;
`else
  localparam int STOP_IDX = 89;
  localparam int NV       = 5;
`endif

  localparam logic [PW-1:0] P0 = 88'hA5_0123456789ABCDEF_5A5A;
  localparam logic [PW-1:0] P1 = 88'h0F_FEDCBA9876543210_C3C3;
  localparam logic [PW-1:0] Q1 = 88'h96_6996699669966996_C3C3;
  localparam logic [PW-1:0] Q2 = 88'h5A_0F0F0F0F0F0F0F0F_A5A5;
  localparam logic [PW-1:0] ONES = {PW{1'b1}};
  localparam logic [PW-1:0] ALT  = 88'hAA_AAAAAAAAAAAAAAAA_AAAA;

  typedef struct {
    logic [PW-1:0] payload;
    logic          stop;
    logic          flip;
    logic          jit;
    int            exp_pv;
    int            exp_fe;
    logic [PW-1:0] exp_packet;
    logic [15:0]   exp_good;
    logic [15:0]   exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          serial_in = 1'b0;
  logic          clear_counts = 1'b0;
  logic [PW-1:0] packet, packet2;
  logic          packet_valid, frame_error, busy;
  logic          pv2, fe2, busy2;
  logic [15:0]   good_count, error_count;
  logic [1:0]    good2, err2;

  int total = 0;
  int bad = 0;
  int n_pv = 0;
  int n_fe = 0;
  int n_both = 0;
  logic [PW-1:0] cap_q[$];

  telemetry_deserialize #(.PACKET_WIDTH(PW), .SAMPLES_PER_BIT(SPB), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .clear_counts(clear_counts),
    .packet(packet), .packet_valid(packet_valid), .frame_error(frame_error),
    .busy(busy), .good_count(good_count), .error_count(error_count)
  );

  // Narrow-counter instance shares the line so saturation is reachable quickly.
  telemetry_deserialize #(.PACKET_WIDTH(PW), .SAMPLES_PER_BIT(SPB), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .clear_counts(clear_counts),
    .packet(packet2), .packet_valid(pv2), .frame_error(fe2),
    .busy(busy2), .good_count(good2), .error_count(err2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (packet_valid) begin
      n_pv++;
      cap_q.push_back(packet);
    end
    if (frame_error) n_fe++;
    if ((packet_valid && frame_error) || (pv2 && fe2)) n_both++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int len);
    serial_in = v;
    repeat (len) @(negedge clk);
  endtask

  task automatic send_frame(input logic [PW-1:0] pl, input logic stop, input logic flip,
                            input logic jit, input int gap);
    int j;
    j = 0;
    drive_bit(1'b1, SPB);
    j++;
    for (int i = PW - 1; i >= 0; i--) begin
      drive_bit(pl[i], (jit && (j % 8 == 7)) ? SPB + 1 : SPB);
      j++;
    end
`ifdef TELEM_DESER_PARITY_EN
    drive_bit((^pl) ^ flip, SPB);
`else
    if (flip) drive_bit(1'b0, 0);
`endif
    drive_bit(stop, SPB);
    drive_bit(1'b0, gap * SPB);
  endtask

  initial begin
    vec_t          vecs[NV];
    int            pv0, fe0;
    logic [15:0]   exp_good, exp_err;
    logic [PW-1:0] pl;

    vecs[0] = '{P0,   1'b0, 1'b0, 1'b0, 1, 0, P0,   16'd1, 16'd0};
    vecs[1] = '{P1,   1'b1, 1'b0, 1'b0, 0, 1, P0,   16'd1, 16'd1};
    vecs[2] = '{ONES, 1'b0, 1'b0, 1'b0, 1, 0, ONES, 16'd2, 16'd1};
    vecs[3] = '{{PW{1'b0}}, 1'b0, 1'b0, 1'b0, 1, 0, {PW{1'b0}}, 16'd3, 16'd1};
    vecs[4] = '{ALT,  1'b0, 1'b0, 1'b1, 1, 0, ALT,  16'd4, 16'd1};
`ifdef TELEM_DESER_PARITY_EN
    vecs[5] = '{P0,   1'b0, 1'b1, 1'b0, 0, 1, ALT,  16'd4, 16'd2};
`endif

    // reset state
    repeat (3) @(negedge clk);
    check("rst_packet", packet, '0);
    check("rst_valid", {87'd0, packet_valid}, '0);
    check("rst_ferr", {87'd0, frame_error}, '0);
    check("rst_busy", {87'd0, busy}, '0);
    check("rst_good", {72'd0, good_count}, '0);
    check("rst_err", {72'd0, error_count}, '0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      pv0 = n_pv;
      fe0 = n_fe;
      send_frame(vecs[k].payload, vecs[k].stop, vecs[k].flip, vecs[k].jit, 3);
      repeat (8) @(negedge clk);
      check($sformatf("v%0d_valid_pulses", k), PW'(n_pv - pv0), PW'(vecs[k].exp_pv));
      check($sformatf("v%0d_err_pulses", k), PW'(n_fe - fe0), PW'(vecs[k].exp_fe));
      check($sformatf("v%0d_packet", k), packet, vecs[k].exp_packet);
      check($sformatf("v%0d_good", k), {72'd0, good_count}, {72'd0, vecs[k].exp_good});
      check($sformatf("v%0d_err", k), {72'd0, error_count}, {72'd0, vecs[k].exp_err});
      check($sformatf("v%0d_busy", k), {87'd0, busy}, '0);
    end
    exp_good = vecs[NV-1].exp_good;
    exp_err  = vecs[NV-1].exp_err;

    // one-clock glitch on an idle line
    pv0 = n_pv;
    fe0 = n_fe;
    serial_in = 1'b1;
    @(negedge clk);
    serial_in = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_valid", PW'(n_pv - pv0), '0);
    check("glitch_ferr", PW'(n_fe - fe0), '0);
    check("glitch_good", {72'd0, good_count}, {72'd0, exp_good});
    check("glitch_err", {72'd0, error_count}, {72'd0, exp_err});
    check("glitch_busy", {87'd0, busy}, '0);

    // back-to-back frames, one idle bit apart, with +1 clock every 8 bits
    pv0 = n_pv;
    cap_q.delete();
    send_frame(Q1, 1'b0, 1'b0, 1'b1, 1);
    send_frame(Q2, 1'b0, 1'b0, 1'b1, 3);
    repeat (8) @(negedge clk);
    exp_good = exp_good + 16'd2;
    check("b2b_valid_pulses", PW'(n_pv - pv0), PW'(2));
    check("b2b_first", (cap_q.size() > 0) ? cap_q[0] : '0, Q1);
    check("b2b_second", (cap_q.size() > 1) ? cap_q[1] : '0, Q2);
    check("b2b_good", {72'd0, good_count}, {72'd0, exp_good});

    // three bad frames drive the 2-bit error counter past all-ones
    pv0 = n_pv;
    fe0 = n_fe;
    for (int k = 0; k < 3; k++) send_frame(P0, 1'b1, 1'b0, 1'b0, 3);
    repeat (8) @(negedge clk);
    exp_err = exp_err + 16'd3;
    check("sat_err_narrow", {86'd0, err2}, PW'(3));
    check("sat_good_narrow", {86'd0, good2}, PW'(3));
    check("sat_err_wide", {72'd0, error_count}, {72'd0, exp_err});
    check("sat_err_pulses", PW'(n_fe - fe0), PW'(3));
    check("sat_valid_pulses", PW'(n_pv - pv0), '0);

    // reset asserted mid-frame during payload bit 40
    pl = P0;
    drive_bit(1'b1, SPB);
    for (int i = PW - 1; i >= PW - 40; i--) drive_bit(pl[i], SPB);
    serial_in = pl[PW-41];
    repeat (2) @(negedge clk);
    check("mid_busy", {87'd0, busy}, PW'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {87'd0, busy}, '0);
    check("mid_rst_packet", packet, '0);
    check("mid_rst_good", {72'd0, good_count}, '0);
    check("mid_rst_err", {72'd0, error_count}, '0);
    check("mid_rst_err_narrow", {86'd0, err2}, '0);
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    pv0 = n_pv;
    send_frame(P0, 1'b0, 1'b0, 1'b0, 3);
    repeat (8) @(negedge clk);
    check("post_rst_valid", PW'(n_pv - pv0), PW'(1));
    check("post_rst_packet", packet, P0);
    check("post_rst_good", {72'd0, good_count}, PW'(1));

    // clear_counts coincident with the good stop-bit strobe
    pv0 = n_pv;
    fork
      send_frame(P1, 1'b0, 1'b0, 1'b0, 3);
      begin
        repeat (4 * (STOP_IDX + 1)) @(negedge clk);
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
      end
    join
    repeat (8) @(negedge clk);
    check("clr_valid", PW'(n_pv - pv0), PW'(1));
    check("clr_packet", packet, P1);
    check("clr_packet_narrow", packet2, P1);
    check("clr_good", {72'd0, good_count}, '0);
    check("clr_err", {72'd0, error_count}, '0);
    check("clr_good_narrow", {86'd0, good2}, '0);
    check("never_both", PW'(n_both), '0);
    check("final_busy_narrow", {87'd0, busy2}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
